delayfixed_loop_edgequal: RTL

Edge-qualification stage that sits directly downstream of the loop-control fixed 1 ns delay cell. It consumes the delay cell's output `o` as its asynchronous input `i`, synchronizes it into the control clock domain, and accepts a level change only after it has been stable for a programmable number of cycles. After each accepted edge it applies a blanking window. It reports accepted edges as single-cycle rise/fall pulses and counts rejected glitches for loop diagnostics.

---
 rtl/delayfixed_loop_edgequal.sv | 137 +++++++++++++
 1 files changed

// File: rtl/delayfixed_loop_edgequal.sv
// Edge qualifier for the output of the fixed 1 ns loop-control delay cell:
// synchronizes it, accepts level changes only after a stable run, then blanks.
module delayfixed_loop_edgequal #(
  parameter int SYNC_STAGES  = 2,
  parameter int QUAL_CYCLES  = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             CELSUB,
  input  logic             i,
  input  logic             en,
  input  logic             glitch_clr,
  output logic             o,
  output logic             rise,
  output logic             fall,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_QUAL   = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // Power/substrate pins carry no logic; folded here so they are not left dangling.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ CELSUB;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   o_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   glitch_q;
  logic [CNT_W-1:0]       glitch_cnt_q;
  logic [CNT_W-1:0]       glitch_cnt_d;
  logic                   glitch_hit;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
    end
  end

  // A pending change that collapses back to the qualified level is a glitch.
  assign glitch_hit = en && (state_q == ST_QUAL) && (s == o_q);

  // Clear takes priority over a coincident glitch increment.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch_hit && (glitch_cnt_q != CNT_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CELCLK or posedge CELRST) begin
    if (CELRST) begin
      state_q      <= ST_STABLE;
      cnt_q        <= '0;
      o_q          <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= glitch_cnt_d;
      if (!en) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_STABLE: begin
            if (s != o_q) begin
              state_q <= ST_QUAL;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_QUAL: begin
            if (s == o_q) begin
              glitch_q <= 1'b1;
              state_q  <= ST_STABLE;
              cnt_q    <= '0;
            end else if (cnt_q == QUAL_LAST) begin
              o_q     <= s;
              rise_q  <= s;
              fall_q  <= ~s;
              state_q <= ST_BLANK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign o          = o_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch     = glitch_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule
